// File: rtl/mux_stream_arbiter.sv
// Two-input round-robin stream arbiter feeding a single-entry output register.
// sel tags the held word with its source channel for the downstream 2:1 mux.
module mux_stream_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_nxt;
    logic   prio;      // 0 = A preferred on contention, 1 = B
    logic   load_en;
    logic   grant_a, grant_b;

    assign out_valid = (state == FULL);
    assign load_en   = !out_valid || out_ready;

    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        state_nxt = state;
        if (a_valid && (!b_valid || !prio))
            grant_a = 1'b1;
        else if (b_valid && (!a_valid || prio))
            grant_b = 1'b1;
        // Gate on rst_n so no upstream word is taken while the register is held in reset.
        a_ready = rst_n && load_en && grant_a;
        b_ready = rst_n && load_en && grant_b;
        if (a_ready || b_ready)
            state_nxt = FULL;
        else if (out_valid && out_ready)
            state_nxt = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            prio     <= 1'b0;
            out_data <= '0;
            sel      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (a_ready) begin
                out_data <= a_data;
                sel      <= 1'b0;
                prio     <= 1'b1;
            end else if (b_ready) begin
                out_data <= b_data;
                sel      <= 1'b1;
                prio     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_stream_arbiter.sv
// Directed bench for mux_stream_arbiter with hand-computed expectations.
module tb_mux_stream_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] a_data, b_data, out_data;
    logic             a_valid, a_ready, b_valid, b_ready;
    logic             out_valid, out_ready, sel;

    int n_chk  = 0;
    int n_fail = 0;

    mux_stream_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel(sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; drive and sample 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic exp_sel [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b0; out_ready = 1'b1;
        a_data = 8'h00; b_data = 8'h00;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sel", sel, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);

        // Single channel A
        step();
        rst_n = 1'b1; a_data = 8'h3C;
        #1;
        chk("single_a_ready", a_ready, 1);
        chk("single_b_ready", b_ready, 0);
        step();
        chk("single_out_data", out_data, 8'h3C);
        chk("single_sel", sel, 0);
        chk("single_out_valid", out_valid, 1);

        // Asynchronous reset while FULL, between clock edges
        a_data = 8'h77;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_sel", sel, 0);
        chk("midrst_a_ready", a_ready, 0);

        // Contention: A,B,A,B starting from reset priority
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22; out_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_a_ready", a_ready, !exp_sel[i]);
            chk("cont_b_ready", b_ready, exp_sel[i]);
            step();
            chk("cont_sel", sel, exp_sel[i]);
            chk("cont_out_data", out_data, exp_sel[i] ? 8'h22 : 8'h11);
            chk("cont_out_valid", out_valid, 1);
        end

        // Backpressure: held word is B's 8'h22, priority back at A
        out_ready = 1'b0; a_data = 8'h33; b_data = 8'h44;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_a_ready", a_ready, 0);
            chk("stall_b_ready", b_ready, 0);
            step();
            chk("stall_out_data", out_data, 8'h22);
            chk("stall_sel", sel, 1);
            chk("stall_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("resume_a_ready", a_ready, 1);
        chk("resume_b_ready", b_ready, 0);
        step();
        chk("resume_out_data", out_data, 8'h33);
        chk("resume_sel", sel, 0);

        // Drain and reload in the same cycle from B
        a_valid = 1'b0; b_valid = 1'b1; b_data = 8'hA5;
        #1;
        chk("reload_b_ready", b_ready, 1);
        chk("reload_a_ready", a_ready, 0);
        step();
        chk("reload_out_data", out_data, 8'hA5);
        chk("reload_sel", sel, 1);
        chk("reload_out_valid", out_valid, 1);

        // Idle drain: register empties but keeps data/sel
        b_valid = 1'b0;
        #1;
        chk("idle_b_ready", b_ready, 0);
        step();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_out_data", out_data, 8'hA5);
        chk("idle_sel", sel, 1);
        step();
        chk("idle2_out_valid", out_valid, 0);

        // Empty with only A valid after a B grant: A still taken
        a_valid = 1'b1; a_data = 8'h5A; out_ready = 1'b0;
        #1;
        chk("empty_a_ready", a_ready, 1);
        step();
        chk("empty_out_data", out_data, 8'h5A);
        chk("empty_sel", sel, 0);
        chk("empty_out_valid", out_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
